// File: rtl/isp_uart_pkg.sv
// Shared types and constants for the fabric-side ISP UART path.
package isp_uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned BIT_CLKS_DEFAULT   = 868;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
  localparam int unsigned DATA_BITS          = 8;
  localparam int unsigned STOP_BITS          = 1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/isp_rx_fifo.sv
// Synchronous show-ahead FIFO; head entry is held in an output register.
module isp_rx_fifo
  import isp_uart_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = DATA_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = dout_q;

  // Output register tracks the post-edge head, bypassing the write when it lands there.
  always_comb begin
    wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_ok  ? rptr_q + 1'b1 : rptr_q;
    if (push_ok && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
      dout_d = wdata_i;
    end else begin
      dout_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/isp_uart_rx.sv
// 8N1 receiver for the MSS MMUART_1 TXD line with majority filtering,
// show-ahead byte FIFO, framing-error pulse and sticky overrun.
module isp_uart_rx
  import isp_uart_pkg::*;
#(
  parameter int unsigned BIT_CLKS   = BIT_CLKS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  input  logic                 CLR_ERR,
  output logic                 BUSY
);

  localparam int unsigned CW = $clog2(BIT_CLKS);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CLKS / 2 - 1);
  localparam logic [IW-1:0] LAST    = IW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, maj_q, maj_prev_q;
  logic [1:0]           hist_q;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push, fifo_full, fifo_empty, expired;

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      // Counter doubles as the consecutive-high run length before idle is trusted.
      WAIT_IDLE: begin
        if (!maj_q)       cnt_d   = BIT_M1;
        else if (expired) state_d = IDLE;
        else              cnt_d   = cnt_q - CW'(1);
      end
      IDLE: begin
        if (maj_prev_q && !maj_q) begin
          cnt_d   = HALF_M1;
          state_d = START;
        end
      end
      START: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else if (maj_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = BIT_M1;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          data_d[idx_q] = maj_q;
          cnt_d         = BIT_M1;
          idx_d         = idx_q + IW'(1);
          if (idx_q == LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else if (maj_q) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          cnt_d       = BIT_M1;
          state_d     = WAIT_IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    // A simultaneous pop makes room, so only a genuinely blocked push is an overrun.
    if (push && fifo_full && !(RX_READY && !fifo_empty)) overrun_d = 1'b1;
    else if (CLR_ERR)                                    overrun_d = 1'b0;
    else                                                 overrun_d = overrun_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      hist_q      <= '1;
      maj_q       <= 1'b1;
      maj_prev_q  <= 1'b1;
      state_q     <= WAIT_IDLE;
      cnt_q       <= BIT_M1;
      idx_q       <= '0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= RXD;
      sync2_q     <= sync1_q;
      hist_q      <= {hist_q[0], sync2_q};
      maj_q       <= maj3({sync2_q, hist_q});
      maj_prev_q  <= maj_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  isp_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESETn),
    .push_i  (push),
    .wdata_i (data_d),
    .pop_i   (RX_READY),
    .rdata_o (RX_DATA),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign RX_VALID  = !fifo_empty;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
  assign BUSY      = !(state_q inside {IDLE, WAIT_IDLE});

endmodule

// File: tb/tb_isp_uart_rx.sv
// Scenario bench for isp_uart_rx at BIT_CLKS=16, FIFO_DEPTH=4.
module tb_isp_uart_rx;

  localparam int BIT = 16;

  logic       CLK = 1'b0;
  logic       RESETn, RXD, RX_READY, CLR_ERR;
  logic [7:0] RX_DATA;
  logic       RX_VALID, FRAME_ERR, OVERRUN, BUSY;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q [$];

  isp_uart_rx #(
    .BIT_CLKS   (16),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .RXD       (RXD),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .CLR_ERR   (CLR_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (FRAME_ERR === 1'b1) fe_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  task automatic bit_period(input logic v, input bit spike);
    RXD = v;
    if (spike) begin
      repeat (7) @(posedge CLK);
      #1 RXD = ~v;
      @(posedge CLK);
      #1 RXD = v;
      repeat (8) @(posedge CLK);
    end else begin
      repeat (BIT) @(posedge CLK);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_bit);
    bit_period(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i], i == spike_bit);
    bit_period(stop, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      n = 0;
      while (RX_VALID !== 1'b1 && n < 400) begin
        @(posedge CLK);
        #1 n++;
      end
      e = exp_q.pop_front();
      checks++;
      if (RX_VALID !== 1'b1) begin
        errors++;
        $display("FAIL %s timeout RX_VALID=%b expected byte %02h", name, RX_VALID, e);
      end else if (RX_DATA !== e) begin
        errors++;
        $display("FAIL %s RX_DATA got %02h expected %02h", name, RX_DATA, e);
      end
      RX_READY = 1'b1;
      @(posedge CLK);
      #1 RX_READY = 1'b0;
    end
    checks++;
    if (RX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty RX_VALID got %b expected 0", name, RX_VALID);
    end
  endtask

  task automatic test_reset;
    RESETn = 1'b0; RXD = 1'b1; RX_READY = 1'b0; CLR_ERR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL reset_data got %02h expected 00", RX_DATA); end
    checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", RX_VALID); end
    checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b expected 0", FRAME_ERR); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b expected 0", OVERRUN); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", BUSY); end
    RESETn = 1'b1;
    repeat (24) @(posedge CLK);
    #1;
  endtask

  task automatic test_basic;
    int n, fe0;
    logic busy_mid;
    n = 0; busy_mid = 1'b0; fe0 = fe_cnt;
    fork
      send_frame(8'hA5, 1'b1, -1);
      begin
        while (RX_VALID !== 1'b1 && n < 400) begin
          @(posedge CLK);
          #1 n++;
          if (n == 80) busy_mid = BUSY;
        end
      end
    join
    checks++; if (n != 157) begin errors++; $display("FAIL basic_latency got %0d edges expected 157", n); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic_busy got %b expected 1", busy_mid); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL basic_ferr got %0d pulses expected 0", fe_cnt - fe0); end
    exp_q.push_back(8'hA5);
    drain("basic");
  endtask

  task automatic test_overrun;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1);
      if (i <= 4) exp_q.push_back(8'(i));
      if (i == 4) begin
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_at_full got %b expected 0", OVERRUN); end
      end
    end
    checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_set got %b expected 1", OVERRUN); end
    CLR_ERR = 1'b1;
    @(posedge CLK);
    #1 CLR_ERR = 1'b0;
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b expected 0", OVERRUN); end
    drain("overrun");
  endtask

  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1);
    RXD = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses got %0d expected 1", fe_cnt - fe0); end
    checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL ferr_nopush got %b expected 0", RX_VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL ferr_busy got %b expected 0", BUSY); end
    send_frame(8'h00, 1'b1, -1);
    repeat (20) @(posedge CLK);
    #1;
    checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL ferr_waitidle got %b expected 0", RX_VALID); end
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_extra got %0d expected 1", fe_cnt - fe0); end
    send_frame(8'h3C, 1'b1, -1);
    exp_q.push_back(8'h3C);
    drain("ferr_recover");
  endtask

  task automatic test_glitch;
    RXD = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RXD = 1'b1;
    repeat (30) @(posedge CLK);
    #1;
    checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b expected 0", RX_VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b expected 0", BUSY); end
    send_frame(8'hFF, 1'b1, 3);
    exp_q.push_back(8'hFF);
    drain("spike");
  endtask

  task automatic test_reset_midframe;
    int fe0;
    send_frame(8'h5A, 1'b1, -1);
    checks++; if (RX_VALID !== 1'b1) begin errors++; $display("FAIL rst_prefill got %b expected 1", RX_VALID); end
    fe0 = fe_cnt;
    fork
      send_frame(8'h00, 1'b1, -1);
      begin
        repeat (72) @(posedge CLK);
        #1 RESETn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %02h expected 00", RX_DATA); end
        checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b expected 0", RX_VALID); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", BUSY); end
        checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL rst_mid_ferr got %b expected 0", FRAME_ERR); end
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL rst_mid_ovr got %b expected 0", OVERRUN); end
        RESETn = 1'b1;
      end
    join
    repeat (40) @(posedge CLK);
    #1;
    checks++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_nobyte got %b expected 0", RX_VALID); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL rst_mid_noferr got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, -1);
    fork
      send_frame(8'h15, 1'b1, -1);
      begin
        repeat (156) @(posedge CLK);
        #1;
        checks++; if (RX_DATA !== 8'h11) begin errors++; $display("FAIL pp_head got %02h expected 11", RX_DATA); end
        RX_READY = 1'b1;
        @(posedge CLK);
        #1 RX_READY = 1'b0;
      end
    join
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL pp_ovr got %b expected 0", OVERRUN); end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h12 + 8'(i));
    drain("push_pop");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_full_push_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
